// File: rtl/timer_share_sched.sv
// Shares one countdown timer between N_REQ requesters: arbitrate, program the timer, wait for expiry, signal done.
// Optional macro TIMER_SHARE_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module timer_share_sched #(
  parameter int          N_REQ      = 4,
  parameter logic [31:0] TIMER_BASE = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] delay,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic                tm_sel,
  output logic                tm_we,
  output logic [31:0]         tm_addr,
  output logic [31:0]         tm_wdata,
  input  logic                tm_timeout
);

  localparam int               IW        = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [31:0]      CTRL_ADDR = TIMER_BASE;
  localparam logic [31:0]      LOAD_ADDR = TIMER_BASE + 32'h4;

  typedef enum logic [2:0] {
    IDLE, WR_LOAD, WR_START, WAIT_PRIME, WR_ONESHOT, WAIT_EXPIRE, WR_STOP, DONE
  } state_t;

  state_t        state;
  logic [31:0]   dly_arr [N_REQ];
  logic [IW-1:0] winner;
  logic          found;

  for (genvar g = 0; g < N_REQ; g++) begin : g_dly
    assign dly_arr[g] = delay[32*g +: 32];
  end

`ifdef TIMER_SHARE_SCHED_FIXED_PRIO_EN
  always_comb begin
    found  = |req;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IW'(i);
    end
  end
`else
  logic [IW-1:0] last;
  logic [IW-1:0] rr_idx;

  // Search starts one past the previous winner and wraps, so nobody gets two grants in a row under contention.
  always_comb begin
    found  = 1'b0;
    winner = last;
    rr_idx = last;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = IW'((int'(last) + k) % N_REQ);
      if (!found && req[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end
`endif

  // Outputs are computed from the state being entered, so each bus write lasts exactly one cycle of its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      tm_sel   <= 1'b0;
      tm_we    <= 1'b0;
      tm_addr  <= '0;
      tm_wdata <= '0;
`ifndef TIMER_SHARE_SCHED_FIXED_PRIO_EN
      last     <= IW'(N_REQ - 1);
`endif
    end else begin
      tm_sel   <= 1'b0;
      tm_we    <= 1'b0;
      tm_addr  <= '0;
      tm_wdata <= '0;
      done     <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state    <= WR_LOAD;
            grant    <= ONE_HOT0 << winner;
            busy     <= 1'b1;
            tm_sel   <= 1'b1;
            tm_we    <= 1'b1;
            tm_addr  <= LOAD_ADDR;
            tm_wdata <= dly_arr[winner];
`ifndef TIMER_SHARE_SCHED_FIXED_PRIO_EN
            last     <= winner;
`endif
          end
        end
        WR_LOAD: begin
          state    <= WR_START;
          tm_sel   <= 1'b1;
          tm_we    <= 1'b1;
          tm_addr  <= CTRL_ADDR;
          tm_wdata <= 32'h3;
        end
        WR_START: state <= WAIT_PRIME;
        // The timer's value is 0 here, so its first pulse just reloads D; switch to one-shot to count it down.
        WAIT_PRIME: begin
          if (tm_timeout) begin
            state    <= WR_ONESHOT;
            tm_sel   <= 1'b1;
            tm_we    <= 1'b1;
            tm_addr  <= CTRL_ADDR;
            tm_wdata <= 32'h1;
          end
        end
        WR_ONESHOT: state <= WAIT_EXPIRE;
        WAIT_EXPIRE: begin
          if (tm_timeout) begin
            state    <= WR_STOP;
            tm_sel   <= 1'b1;
            tm_we    <= 1'b1;
            tm_addr  <= CTRL_ADDR;
            tm_wdata <= 32'h0;
          end
        end
        WR_STOP: begin
          state <= DONE;
          done  <= grant;
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
